load_store_unit: RTL and testbench

Sits between the CPU datapath and the 4 KB word-organised data memory. Takes one load or store request at a time, splits accesses that cross a word boundary into two word accesses, and performs every store as a same-cycle read-modify-write of whole words. Loads return sign- or zero-extended data to the CPU. Out-of-window addresses, reserved sizes and disallowed misalignment are rejected with a fault pulse and never touch memory.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 tb/tb_load_store_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states,
// the default memory window and the byte-count helper.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_RSVD = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    // Required value of addr[31:16] for an access to reach data memory.
    localparam logic [15:0] MEM_ADDR_DEFAULT = 16'h1000;

    typedef enum logic [1:0] {
        IDLE,
        W0,
        W1,
        DONE
    } lsu_state_e;

    // Number of bytes moved by a size code; the reserved code never gets
    // past the legality check, so its value here does not matter.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational byte lane logic: byte mask generation, store data
// shift and read-modify-write merge, and load shift with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  req_off,
    input  logic [1:0]  req_size,
    output logic [7:0]  req_mask,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [7:0]  mask,
    input  logic        hi_sel,
    input  logic [31:0] old_word,
    output logic [31:0] merged,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [31:0] ld_result
);

    // Bytes touched across the two-word window starting at the word address.
    function automatic logic [7:0] gen_mask(input logic [1:0] o, input logic [1:0] s);
        logic [7:0] base;
        base = (8'd1 << size_bytes(s)) - 8'd1;
        return base << o;
    endfunction

    // Shift store data into byte lanes, pick the word being written and
    // keep the old memory bytes wherever the mask is clear.
    function automatic logic [31:0] store_merge(input logic [31:0] wd, input logic [1:0] o,
                                                input logic [7:0] m, input logic hi,
                                                input logic [31:0] old_w);
        logic [63:0] shifted;
        logic [31:0] new_w;
        logic [3:0]  lane_m;
        logic [31:0] w;
        shifted = {32'd0, wd} << {o, 3'b000};
        new_w   = hi ? shifted[63:32] : shifted[31:0];
        lane_m  = hi ? m[7:4] : m[3:0];
        for (int b = 0; b < 4; b++) begin
            w[8*b +: 8] = lane_m[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return w;
    endfunction

    // Right-justify the addressed bytes of {hi, lo} and extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] lo, input logic [31:0] hi,
                                                input logic [1:0] o, input logic [1:0] s,
                                                input logic sg);
        logic [63:0] r;
        r = {hi, lo} >> {o, 3'b000};
        case (s)
            SZ_BYTE: return {{24{sg & r[7]}}, r[7:0]};
            SZ_HALF: return {{16{sg & r[15]}}, r[15:0]};
            default: return r[31:0];
        endcase
    endfunction

    assign req_mask  = gen_mask(req_off, req_size);
    assign merged    = store_merge(wdata, off, mask, hi_sel, old_word);
    assign ld_result = load_extend(ld_lo, ld_hi, off, size, sgn);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the CPU datapath and word-organised data memory.
// One request at a time; word-crossing accesses become two word cycles,
// stores are whole-word read-modify-writes, illegal requests fault.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [15:0] MEM_ADDR        = MEM_ADDR_DEFAULT,
    parameter bit          ALLOW_UNALIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        cpu_fault,
    output logic [31:0] cpu_rdata,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_we,
    output logic        mem_re
);

    lsu_state_e  state, state_next;
    logic        we_q, signed_q, fault_q;
    logic [1:0]  size_q, off_q;
    logic [29:0] word_q;
    logic [7:0]  mask_q;
    logic [31:0] wdata_q, lo_q, rdata_q;

    logic [7:0]  req_mask;
    logic [15:0] next_hi;
    logic        req_span, req_legal;
    logic [31:0] merged, ld_result, ld_lo;
    logic        span_q, last_cycle;

    lsu_align u_align (
        .req_off   (cpu_addr[1:0]),
        .req_size  (cpu_size),
        .req_mask  (req_mask),
        .off       (off_q),
        .size      (size_q),
        .sgn       (signed_q),
        .wdata     (wdata_q),
        .mask      (mask_q),
        .hi_sel    (state == W1),
        .old_word  (mem_rdata),
        .merged    (merged),
        .ld_lo     (ld_lo),
        .ld_hi     (mem_rdata),
        .ld_result (ld_result)
    );

    // Legality of the request presented in IDLE. The second word's upper
    // half only changes when bits [15:2] carry out on the +4.
    always_comb begin
        req_span  = |req_mask[7:4];
        next_hi   = cpu_addr[31:16] + {15'd0, &cpu_addr[15:2]};
        req_legal = (cpu_addr[31:16] == MEM_ADDR) && (cpu_size != SZ_RSVD) &&
                    (!req_span || (ALLOW_UNALIGNED && (next_hi == MEM_ADDR)));
    end

    assign span_q     = |mask_q[7:4];
    assign last_cycle = (state == W1) || ((state == W0) && !span_q);
    assign ld_lo      = (state == W1) ? lo_q : mem_rdata;

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cpu_valid) state_next = req_legal ? W0 : DONE;
            W0:      state_next = span_q ? W1 : DONE;
            W1:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // CPU and memory outputs decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned and infers a latch.
        cpu_busy  = (state == W0) || (state == W1);
        cpu_done  = (state == DONE);
        cpu_fault = (state == DONE) && fault_q;
        cpu_rdata = rdata_q;
        mem_size  = SZ_WORD;
        mem_re    = cpu_busy && !reset;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state)
            W0: begin
                mem_addr  = {word_q, 2'b00};
                mem_wdata = merged;
                mem_we    = we_q && (|mask_q[3:0]) && !reset;
            end
            W1: begin
                mem_addr  = {word_q + 30'd1, 2'b00};
                mem_wdata = merged;
                mem_we    = we_q && (|mask_q[7:4]) && !reset;
            end
            default: ;
        endcase
    end

    // State register, request latch and load capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the request and capture registers are reset as well, so cpu_rdata starts at zero.
            state    <= IDLE;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            fault_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            off_q    <= 2'd0;
            word_q   <= '0;
            mask_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            if (state == IDLE && cpu_valid) begin
                fault_q  <= !req_legal;
                we_q     <= cpu_we;
                signed_q <= cpu_signed;
                size_q   <= cpu_size;
                off_q    <= cpu_addr[1:0];
                word_q   <= cpu_addr[31:2];
                mask_q   <= req_mask;
                wdata_q  <= cpu_wdata;
            end
            if (state == W0) lo_q <= mem_rdata;
            if (last_cycle && !we_q) rdata_q <= ld_result;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-addressed transaction model predicts
// each request's result and timeline, one compare thread checks the DUT
// every cycle, and hand-computed literals pin the model.
module tb_load_store_unit;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        cpu_valid, cpu_we, cpu_signed;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_busy, cpu_done, cpu_fault;
    logic [31:0] cpu_rdata, mem_addr, mem_rdata, mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_we, mem_re;

    load_store_unit #(.MEM_ADDR(16'h1000), .ALLOW_UNALIGNED(1'b1)) u_dut (
        .clock(clock), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_signed(cpu_signed),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_fault(cpu_fault),
        .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_we(mem_we), .mem_re(mem_re)
    );

    // Second instance with word-crossing accesses disallowed.
    logic        s_valid, s_we, s_signed;
    logic [31:0] s_addr, s_wdata;
    logic [1:0]  s_size;
    logic        s_busy, s_done, s_fault;
    logic [31:0] s_rdata, s_mem_addr, s_mem_rdata, s_mem_wdata;
    logic [1:0]  s_mem_size;
    logic        s_mem_we, s_mem_re;

    assign s_mem_rdata = 32'h8765_4321;

    load_store_unit #(.MEM_ADDR(16'h1000), .ALLOW_UNALIGNED(1'b0)) u_strict (
        .clock(clock), .reset(reset),
        .cpu_valid(s_valid), .cpu_we(s_we), .cpu_addr(s_addr),
        .cpu_wdata(s_wdata), .cpu_size(s_size), .cpu_signed(s_signed),
        .cpu_busy(s_busy), .cpu_done(s_done), .cpu_fault(s_fault),
        .cpu_rdata(s_rdata), .mem_addr(s_mem_addr), .mem_rdata(s_mem_rdata),
        .mem_wdata(s_mem_wdata), .mem_size(s_mem_size), .mem_we(s_mem_we), .mem_re(s_mem_re)
    );

    // 4 KB word memory behind the main instance.
    logic [31:0] mem [0:1023];
    logic        mem_clear;
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    int cyc = 0;
    int we_count = 0;
    always @(posedge clock) begin
        cyc++;
        if (mem_we) we_count++;
    end

    int checks = 0;
    int errors = 0;

    // Model state and the expectation for the request in flight.
    logic [7:0]  mbyte [0:4095];
    logic [31:0] last_rdata = '0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_word = '0;
    int          exp_s = 0, exp_len = 0, exp_we = 0, we_base = 0;
    bit          exp_fault = 0, exp_load = 0, active = 0, cmp_on = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the expectation of the request in flight.
    task automatic compare_loop();
        int   rel;
        logic e_busy, e_done;
        forever begin
            @(negedge clock);
            #1;
            if (cmp_on && reset) begin
                check("mem_we_in_reset", {31'd0, mem_we}, 32'd0);
                check("mem_re_in_reset", {31'd0, mem_re}, 32'd0);
            end else if (cmp_on) begin
                rel    = cyc - exp_s;
                e_busy = active && rel >= 0 && rel < exp_len;
                e_done = active && rel == exp_len;
                check("cpu_busy", {31'd0, cpu_busy}, {31'd0, e_busy});
                check("mem_re", {31'd0, mem_re}, {31'd0, e_busy});
                check("cpu_done", {31'd0, cpu_done}, {31'd0, e_done});
                check("cpu_fault", {31'd0, cpu_fault}, {31'd0, e_done && exp_fault});
                if (e_busy) check("mem_addr", mem_addr, exp_word + 32'(4 * rel));
                else        check("mem_we_idle", {31'd0, mem_we}, 32'd0);
                if (e_done) begin
                    check("mem_we_count", 32'(we_count - we_base), 32'(exp_we));
                    if (!exp_fault) check("cpu_rdata", cpu_rdata, exp_load ? exp_rdata : last_rdata);
                end
            end
        end
    endtask

    // Present one request at a negedge in IDLE; returns at the negedge of
    // the IDLE cycle after completion. hold keeps cpu_valid high with junk;
    // abort_w1 pulses reset during the second word cycle.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sgn, input bit hold, input bit abort_w1);
        int          n, len;
        bit          span, fault;
        logic [31:0] a, addr4, val;
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        span  = (int'(addr[1:0]) + n) > 4;
        addr4 = addr + 32'd4;
        fault = (addr[31:16] != 16'h1000) || (size == 2'd2) || (span && addr4[31:16] != 16'h1000);
        len   = fault ? 0 : (span ? 2 : 1);
        if (!fault && we) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                if (!abort_w1 || (int'(addr[1:0]) + i) < 4) mbyte[a[11:0]] = wdata[8*i +: 8];
            end
        end else if (!fault) begin
            val = '0;
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                val[8*i +: 8] = mbyte[a[11:0]];
            end
            if (sgn && val[8*n-1]) for (int i = 8 * n; i < 32; i++) val[i] = 1'b1;
            exp_rdata  = val;
            last_rdata = val;
        end
        exp_s     = cyc + 1;
        exp_len   = len;
        exp_fault = fault;
        exp_load  = !we;
        exp_word  = {addr[31:2], 2'b00};
        exp_we    = (fault || !we) ? 0 : (span ? 2 : 1);
        we_base   = we_count;
        active    = 1'b1;
        cpu_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        cpu_size = size; cpu_signed = sgn;
        for (int j = 0; j < len + 2; j++) begin
            @(negedge clock);
            if (hold) begin
                cpu_valid  = 1'b1;
                cpu_we     = 1'($urandom_range(0, 1));
                cpu_addr   = 32'h1000_0020 + $urandom_range(0, 15);
                cpu_wdata  = $urandom;
                cpu_size   = ($urandom_range(0, 1) == 0) ? 2'd3 : 2'd0;
                cpu_signed = 1'($urandom_range(0, 1));
            end else begin
                cpu_valid = 1'b0;
            end
            if (abort_w1 && j == 1) reset = 1'b1;
            if (abort_w1 && j == 2) begin
                reset      = 1'b0;
                active     = 1'b0;
                last_rdata = '0;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            compare_loop();
        join_none
        reset = 1'b1; mem_clear = 1'b1;
        cpu_valid = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_size = '0; cpu_signed = 0;
        s_valid = 0; s_we = 0; s_addr = '0; s_wdata = '0; s_size = '0; s_signed = 0;
        for (int i = 0; i < 4096; i++) mbyte[i] = 8'h00;
        repeat (3) @(negedge clock);
        mem_clear = 1'b0;

        // Reset values while reset is still asserted.
        check("rst_busy", {31'd0, cpu_busy}, 32'd0);
        check("rst_done", {31'd0, cpu_done}, 32'd0);
        check("rst_fault", {31'd0, cpu_fault}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_re", {31'd0, mem_re}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("mem_size", {30'd0, mem_size}, 32'd3);
        reset  = 1'b0;
        cmp_on = 1'b1;
        @(negedge clock);

        // Aligned word store then load.
        issue(1, 32'h1000_0010, 32'hDEAD_BEEF, 2'd3, 0, 0, 0);
        check("mem_word_10", mem[4], 32'hDEAD_BEEF);
        issue(0, 32'h1000_0010, 32'h0, 2'd3, 0, 0, 0);
        check("model_word_load", exp_rdata, 32'hDEAD_BEEF);

        // Sign/zero extension.
        issue(1, 32'h1000_0010, 32'h8000_0000, 2'd3, 0, 0, 0);
        issue(0, 32'h1000_0013, 32'h0, 2'd0, 1, 0, 0);
        check("model_sbyte", exp_rdata, 32'hFFFF_FF80);
        issue(0, 32'h1000_0013, 32'h0, 2'd0, 0, 0, 0);
        check("model_ubyte", exp_rdata, 32'h0000_0080);
        issue(0, 32'h1000_0012, 32'h0, 2'd1, 1, 0, 0);
        check("model_shalf", exp_rdata, 32'hFFFF_8000);

        // Word-crossing store and load.
        issue(1, 32'h1000_0004, 32'hAAAA_AAAA, 2'd3, 0, 0, 0);
        issue(1, 32'h1000_0008, 32'hBBBB_BBBB, 2'd3, 0, 0, 0);
        issue(1, 32'h1000_0006, 32'h1122_3344, 2'd3, 0, 0, 0);
        check("model_span_len", 32'(exp_len), 32'd2);
        check("span_word_4", mem[1], 32'h3344_AAAA);
        check("span_word_8", mem[2], 32'hBBBB_1122);
        issue(0, 32'h1000_0006, 32'h0, 2'd3, 0, 0, 0);
        check("model_span_load", exp_rdata, 32'h1122_3344);

        // Faults: out of window, reserved size, second word out of window.
        issue(1, 32'h2000_0000, 32'h1234_5678, 2'd3, 0, 0, 0);
        check("model_fault_window", {31'd0, exp_fault}, 32'd1);
        issue(0, 32'h1000_0000, 32'h0, 2'd2, 0, 0, 0);
        check("model_fault_rsvd", {31'd0, exp_fault}, 32'd1);
        issue(1, 32'h1000_FFFE, 32'h5555_5555, 2'd3, 0, 0, 0);
        check("model_fault_cross", {31'd0, exp_fault}, 32'd1);

        // Reset during the second word of a crossing store.
        issue(1, 32'h1000_0004, 32'hAAAA_AAAA, 2'd3, 0, 0, 0);
        issue(1, 32'h1000_0008, 32'hBBBB_BBBB, 2'd3, 0, 0, 0);
        issue(1, 32'h1000_0006, 32'h1122_3344, 2'd3, 0, 0, 1);
        check("abort_word_4", mem[1], 32'h3344_AAAA);
        check("abort_word_8", mem[2], 32'hBBBB_BBBB);
        issue(0, 32'h1000_0008, 32'h0, 2'd3, 0, 0, 0);
        check("model_after_abort", exp_rdata, 32'hBBBB_BBBB);

        // cpu_valid held high with junk between requests.
        issue(1, 32'h1000_0020, 32'hCAFE_F00D, 2'd3, 0, 1, 0);
        issue(0, 32'h1000_0021, 32'h0, 2'd1, 0, 1, 0);
        check("model_hold_half", exp_rdata, 32'h0000_FEF0);
        issue(0, 32'h1000_0023, 32'h0, 2'd1, 1, 1, 0);
        check("model_hold_span", exp_rdata, 32'h0000_00CA);
        issue(0, 32'h1000_0020, 32'h0, 2'd3, 0, 1, 0);
        cpu_valid = 1'b0;
        check("hold_word_20", mem[8], 32'hCAFE_F00D);
        check("hold_word_24", mem[9], 32'h0000_0000);
        @(negedge clock);

        // Strict instance: crossing accesses fault, aligned ones work.
        s_valid = 1; s_we = 0; s_addr = 32'h1000_0003; s_size = 2'd1; s_signed = 0;
        @(negedge clock);
        s_valid = 0;
        check("strict_half_done", {31'd0, s_done}, 32'd1);
        check("strict_half_fault", {31'd0, s_fault}, 32'd1);
        check("strict_half_busy", {31'd0, s_busy}, 32'd0);
        check("strict_half_re", {31'd0, s_mem_re}, 32'd0);
        @(negedge clock);
        check("strict_idle_done", {31'd0, s_done}, 32'd0);
        s_valid = 1; s_we = 1; s_addr = 32'h1000_0001; s_wdata = 32'hFFFF_FFFF; s_size = 2'd3;
        @(negedge clock);
        s_valid = 0;
        check("strict_word_fault", {31'd0, s_fault}, 32'd1);
        check("strict_word_we", {31'd0, s_mem_we}, 32'd0);
        @(negedge clock);
        s_valid = 1; s_we = 0; s_addr = 32'h1000_0002; s_size = 2'd1; s_signed = 1;
        @(negedge clock);
        s_valid = 0;
        check("strict_aligned_busy", {31'd0, s_busy}, 32'd1);
        check("strict_aligned_addr", s_mem_addr, 32'h1000_0000);
        check("strict_aligned_we", {31'd0, s_mem_we}, 32'd0);
        @(negedge clock);
        check("strict_aligned_done", {31'd0, s_done}, 32'd1);
        check("strict_aligned_fault", {31'd0, s_fault}, 32'd0);
        check("strict_aligned_rdata", s_rdata, 32'hFFFF_8765);
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
